// File: rtl/com_uart_baud_gen.sv
`default_nettype none
// com_uart_baud_gen: synchronous UART baud enables; gated TX channel plus alignable oversampled RX channel.
// Rev 1.0
module com_uart_baud_gen #(
  parameter int PRESCALE           = 21,
  parameter int BASE_TICKS_LOG2    = 8,
  parameter int NUM_RATES          = 4,
  parameter int OVERSAMPLE_LOG2    = 4,
  parameter int BAUDRATE_SEL_WIDTH = $clog2(NUM_RATES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BAUDRATE_SEL_WIDTH-1:0] baudrate_sel,
  input  logic                          FIFO_empty,
  input  logic                          ctrl_idle_state,
  input  logic                          rx_en,
  input  logic                          rx_align,
  output logic                          tx_tick,
  output logic                          baudrate_clk,
  output logic                          rx_tick,
  output logic                          rx_mid,
  output logic [BAUDRATE_SEL_WIDTH-1:0] tx_sel_active,
  output logic [BAUDRATE_SEL_WIDTH-1:0] rx_sel_active
);

  localparam int SW = BAUDRATE_SEL_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = BASE_TICKS_LOG2;

  localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] ALL_ONES    = {BW{1'b1}};
  localparam logic [SW:0]   NUM_RATES_V = (SW + 1)'(NUM_RATES);

  if (BASE_TICKS_LOG2 < (NUM_RATES - 1) + OVERSAMPLE_LOG2 + 1) begin : g_cfg_ticks_err
    $error("com_uart_baud_gen: BASE_TICKS_LOG2 too small for NUM_RATES/OVERSAMPLE_LOG2");
  end

  if (PRESCALE < 2) begin : g_cfg_prescale_err
    $error("com_uart_baud_gen: PRESCALE must be at least 2");
  end

  logic [SW-1:0] sel_clamped;

  always_comb begin
    sel_clamped = baudrate_sel;
    if ({1'b0, baudrate_sel} >= NUM_RATES_V) sel_clamped = '0;
  end

  // TX channel. Outputs are registered decodes of the next counter state, so
  // tx_tick lands in the wrap cycle itself and baudrate_clk leads by one cycle.
  logic          tx_run;
  logic          tx_base;
  logic [PW-1:0] tx_presc, tx_presc_nx;
  logic [BW-1:0] tx_bit, tx_bit_nx;
  logic [BW-1:0] tx_last, tx_half_m1;
  logic          tx_wrap_nx;
  logic          tx_tick_nx, baud_nx;

  always_comb begin
    tx_run      = ~(FIFO_empty & ctrl_idle_state);
    tx_last     = ALL_ONES >> tx_sel_active;
    tx_half_m1  = tx_last >> 1;
    tx_base     = (tx_presc == PRE_LAST);
    tx_presc_nx = '0;
    tx_bit_nx   = '0;
    if (tx_run) begin
      tx_presc_nx = tx_base ? '0 : tx_presc + 1'b1;
      tx_bit_nx   = tx_bit;
      if (tx_base) tx_bit_nx = (tx_bit == tx_last) ? '0 : tx_bit + 1'b1;
    end
    tx_wrap_nx = (tx_presc_nx == PRE_LAST) && (tx_bit_nx == tx_last);
    tx_tick_nx = tx_wrap_nx;
    baud_nx    = ((tx_bit_nx > tx_half_m1) && !tx_wrap_nx) ||
                 ((tx_bit_nx == tx_half_m1) && (tx_presc_nx == PRE_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_presc      <= '0;
      tx_bit        <= '0;
      tx_sel_active <= '0;
      tx_tick       <= 1'b0;
      baudrate_clk  <= 1'b0;
    end else begin
      tx_presc     <= tx_presc_nx;
      tx_bit       <= tx_bit_nx;
      tx_tick      <= tx_tick_nx;
      baudrate_clk <= baud_nx;
      if (!tx_run) tx_sel_active <= sel_clamped;
    end
  end

  // RX channel. A rising rx_en restarts the phase exactly like rx_align.
  logic          rx_en_d;
  logic          rx_start;
  logic          rx_base;
  logic [PW-1:0] rx_presc, rx_presc_nx;
  logic [BW-1:0] rx_bit, rx_bit_nx;
  logic [BW-1:0] rx_last, rx_half_m1, rx_os_last;
  logic          rx_tick_nx, rx_mid_nx;

  always_comb begin
    rx_start    = rx_en & (rx_align | ~rx_en_d);
    rx_last     = ALL_ONES >> rx_sel_active;
    rx_half_m1  = rx_last >> 1;
    rx_os_last  = (ALL_ONES >> OVERSAMPLE_LOG2) >> rx_sel_active;
    rx_base     = (rx_presc == PRE_LAST);
    rx_presc_nx = '0;
    rx_bit_nx   = '0;
    if (rx_en && !rx_start) begin
      rx_presc_nx = rx_base ? '0 : rx_presc + 1'b1;
      rx_bit_nx   = rx_bit;
      if (rx_base) rx_bit_nx = (rx_bit == rx_last) ? '0 : rx_bit + 1'b1;
    end
    rx_tick_nx = (rx_presc_nx == PRE_LAST) && ((rx_bit_nx & rx_os_last) == rx_os_last);
    rx_mid_nx  = (rx_presc_nx == PRE_LAST) && (rx_bit_nx == rx_half_m1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_en_d       <= 1'b0;
      rx_presc      <= '0;
      rx_bit        <= '0;
      rx_sel_active <= '0;
      rx_tick       <= 1'b0;
      rx_mid        <= 1'b0;
    end else begin
      rx_en_d  <= rx_en;
      rx_presc <= rx_presc_nx;
      rx_bit   <= rx_bit_nx;
      rx_tick  <= rx_tick_nx;
      rx_mid   <= rx_mid_nx;
      if (!rx_en || rx_start) rx_sel_active <= sel_clamped;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_com_uart_baud_gen.sv
`default_nettype none
// tb_com_uart_baud_gen: directed timing checks of the baud generator against hand-computed cycle numbers.
module tb_com_uart_baud_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] baudrate_sel;
  logic       FIFO_empty, ctrl_idle_state, rx_en, rx_align;
  logic       tx_tick, baudrate_clk, rx_tick, rx_mid;
  logic [1:0] tx_sel_active, rx_sel_active;

  logic [1:0] sel3;
  logic       fifo3, rx_en3, rx_align3;
  logic       tx_tick3, baudrate_clk3, rx_tick3, rx_mid3;
  logic [1:0] tx_sel_active3, rx_sel_active3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int tx_ticks[$];
  int tx_rises[$];
  int tx_high;
  int tx_overlap;
  int rx_ticks[$];
  int rx_mids[$];
  int tx_busy;

  always #5 clk = ~clk;

  com_uart_baud_gen dut (
    .clk(clk), .rst_n(rst_n), .baudrate_sel(baudrate_sel),
    .FIFO_empty(FIFO_empty), .ctrl_idle_state(ctrl_idle_state),
    .rx_en(rx_en), .rx_align(rx_align),
    .tx_tick(tx_tick), .baudrate_clk(baudrate_clk),
    .rx_tick(rx_tick), .rx_mid(rx_mid),
    .tx_sel_active(tx_sel_active), .rx_sel_active(rx_sel_active)
  );

  com_uart_baud_gen #(.NUM_RATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .baudrate_sel(sel3),
    .FIFO_empty(fifo3), .ctrl_idle_state(ctrl_idle_state),
    .rx_en(rx_en3), .rx_align(rx_align3),
    .tx_tick(tx_tick3), .baudrate_clk(baudrate_clk3),
    .rx_tick(rx_tick3), .rx_mid(rx_mid3),
    .tx_sel_active(tx_sel_active3), .rx_sel_active(rx_sel_active3)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic disable_tx(input logic [1:0] s);
    FIFO_empty      = 1'b1;
    ctrl_idle_state = 1'b1;
    baudrate_sel    = s;
    repeat (3) step();
  endtask

  task automatic run_tx(input int n);
    logic prev;
    tx_ticks.delete();
    tx_rises.delete();
    tx_high    = 0;
    tx_overlap = 0;
    prev       = baudrate_clk;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx_tick) tx_ticks.push_back(cyc);
      if (baudrate_clk && !prev) tx_rises.push_back(cyc);
      if (baudrate_clk) tx_high++;
      if (baudrate_clk && tx_tick) tx_overlap++;
      prev = baudrate_clk;
    end
  endtask

  task automatic run_rx(input int n);
    rx_ticks.delete();
    rx_mids.delete();
    tx_busy = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (rx_tick) rx_ticks.push_back(cyc);
      if (rx_mid) rx_mids.push_back(cyc);
      if (tx_tick || baudrate_clk) tx_busy++;
    end
  endtask

  task automatic test_reset();
    int e;
    int got;
    rst_n = 1'b0; FIFO_empty = 1'b1; ctrl_idle_state = 1'b1; rx_en = 1'b0; rx_align = 1'b0;
    baudrate_sel = 2'd1; sel3 = 2'd0; fifo3 = 1'b1; rx_en3 = 1'b0; rx_align3 = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_tick, baudrate_clk, rx_tick, rx_mid, tx_sel_active, rx_sel_active} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000000",
               {tx_tick, baudrate_clk, rx_tick, rx_mid, tx_sel_active, rx_sel_active});
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (tx_sel_active !== 2'd1 || rx_sel_active !== 2'd1) begin
      errors++;
      $display("FAIL idle_sel_reload: got tx=%0d rx=%0d expected 1/1", tx_sel_active, rx_sel_active);
    end
    FIFO_empty = 1'b0;
    run_tx(1500);
    checks++;
    if (baudrate_clk !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_high: got baudrate_clk=%b expected 1", baudrate_clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_tick, baudrate_clk, rx_tick, rx_mid, tx_sel_active, rx_sel_active} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000000",
               {tx_tick, baudrate_clk, rx_tick, rx_mid, tx_sel_active, rx_sel_active});
    end
    step();
    rst_n = 1'b1;
    disable_tx(2'd1);
    FIFO_empty = 1'b0;
    e = cyc;
    run_tx(2700);
    got = (tx_ticks.size() > 0) ? tx_ticks[0] - e : -1;
    checks++;
    if (got !== 2687) begin
      errors++;
      $display("FAIL reset_first_tick: got offset %0d expected 2687", got);
    end
  endtask

  task automatic test_ctrl_gate();
    int e;
    int got;
    disable_tx(2'd1);
    ctrl_idle_state = 1'b0;
    e = cyc;
    run_tx(2700);
    got = (tx_ticks.size() > 0) ? tx_ticks[0] - e : -1;
    checks++;
    if (got !== 2687) begin
      errors++;
      $display("FAIL ctrl_gate_tick: got offset %0d expected 2687", got);
    end
    ctrl_idle_state = 1'b1;
  endtask

  task automatic test_tx_rate();
    int e;
    int t0, t1, t2, r0;
    disable_tx(2'd1);
    FIFO_empty = 1'b0;
    e = cyc;
    run_tx(8100);
    t0 = (tx_ticks.size() > 0) ? tx_ticks[0] - e : -1;
    t1 = (tx_ticks.size() > 1) ? tx_ticks[1] - e : -1;
    t2 = (tx_ticks.size() > 2) ? tx_ticks[2] - e : -1;
    r0 = (tx_rises.size() > 0) ? tx_rises[0] - e : -1;
    checks++;
    if (tx_ticks.size() !== 3 || t0 !== 2687 || t1 !== 5375 || t2 !== 8063) begin
      errors++;
      $display("FAIL tx_ticks_s1: got n=%0d %0d %0d %0d expected n=3 2687 5375 8063",
               tx_ticks.size(), t0, t1, t2);
    end
    checks++;
    if (r0 !== 1343) begin
      errors++;
      $display("FAIL baud_rise_s1: got offset %0d expected 1343", r0);
    end
    checks++;
    if (tx_high !== 4032 || tx_overlap !== 0) begin
      errors++;
      $display("FAIL baud_high_s1: got high=%0d overlap=%0d expected 4032/0", tx_high, tx_overlap);
    end
  endtask

  task automatic test_sel_freeze();
    int e, e2;
    int t0, t1;
    disable_tx(2'd3);
    FIFO_empty = 1'b0;
    e = cyc;
    run_tx(300);
    baudrate_sel = 2'd0;
    step();
    checks++;
    if (tx_sel_active !== 2'd3) begin
      errors++;
      $display("FAIL tx_sel_frozen: got %0d expected 3", tx_sel_active);
    end
    run_tx(1100);
    t0 = (tx_ticks.size() > 0) ? tx_ticks[0] - e : -1;
    t1 = (tx_ticks.size() > 1) ? tx_ticks[1] - e : -1;
    checks++;
    if (tx_ticks.size() !== 2 || t0 !== 671 || t1 !== 1343) begin
      errors++;
      $display("FAIL tx_ticks_s3: got n=%0d %0d %0d expected n=2 671 1343", tx_ticks.size(), t0, t1);
    end
    FIFO_empty = 1'b1;
    step();
    checks++;
    if (tx_sel_active !== 2'd0) begin
      errors++;
      $display("FAIL tx_sel_idle_reload: got %0d expected 0", tx_sel_active);
    end
    run_tx(700);
    checks++;
    if (tx_ticks.size() !== 0 || tx_high !== 0) begin
      errors++;
      $display("FAIL tx_quiet_disabled: got ticks=%0d high=%0d expected 0/0", tx_ticks.size(), tx_high);
    end
    FIFO_empty = 1'b0;
    e2 = cyc;
    run_tx(5400);
    t0 = (tx_ticks.size() > 0) ? tx_ticks[0] - e2 : -1;
    checks++;
    if (tx_ticks.size() !== 1 || t0 !== 5375) begin
      errors++;
      $display("FAIL tx_ticks_s0: got n=%0d %0d expected n=1 5375", tx_ticks.size(), t0);
    end
    FIFO_empty = 1'b1;
  endtask

  task automatic test_rx_align();
    int a;
    int m0, m1, k0, k1;
    FIFO_empty = 1'b1;
    baudrate_sel = 2'd2;
    rx_en = 1'b0;
    repeat (3) step();
    rx_en = 1'b1;
    repeat (50) step();
    rx_align = 1'b1;
    a = cyc;
    step();
    rx_align = 1'b0;
    run_rx(2200);
    m0 = (rx_mids.size() > 0) ? rx_mids[0] - a : -1;
    m1 = (rx_mids.size() > 1) ? rx_mids[1] - a : -1;
    k0 = (rx_ticks.size() > 0) ? rx_ticks[0] - a : -1;
    k1 = (rx_ticks.size() > 1) ? rx_ticks[1] - a : -1;
    checks++;
    if (rx_mids.size() !== 2 || m0 !== 672 || m1 !== 2016) begin
      errors++;
      $display("FAIL rx_mid_s2: got n=%0d %0d %0d expected n=2 672 2016", rx_mids.size(), m0, m1);
    end
    checks++;
    if (rx_ticks.size() !== 26 || k0 !== 84 || k1 !== 168) begin
      errors++;
      $display("FAIL rx_tick_s2: got n=%0d %0d %0d expected n=26 84 168", rx_ticks.size(), k0, k1);
    end
    checks++;
    if (tx_busy !== 0 || rx_sel_active !== 2'd2) begin
      errors++;
      $display("FAIL rx_isolation: got tx_busy=%0d rx_sel=%0d expected 0/2", tx_busy, rx_sel_active);
    end
  endtask

  task automatic test_rx_realign();
    int r, a1, a2;
    int k0, m0;
    rx_en = 1'b0;
    baudrate_sel = 2'd2;
    repeat (3) step();
    checks++;
    if ((rx_tick | rx_mid) !== 1'b0 || rx_sel_active !== 2'd2) begin
      errors++;
      $display("FAIL rx_disabled: got tick=%b mid=%b sel=%0d expected 0/0/2", rx_tick, rx_mid, rx_sel_active);
    end
    rx_en = 1'b1;
    r = cyc;
    run_rx(100);
    k0 = (rx_ticks.size() > 0) ? rx_ticks[0] - r : -1;
    checks++;
    if (rx_ticks.size() !== 1 || k0 !== 84) begin
      errors++;
      $display("FAIL rx_en_rise_phase: got n=%0d %0d expected n=1 84", rx_ticks.size(), k0);
    end
    rx_align = 1'b1;
    a1 = cyc;
    step();
    rx_align = 1'b0;
    run_rx(399);
    a2 = cyc;
    k0 = (rx_ticks.size() > 0) ? rx_ticks[0] - a1 : -1;
    checks++;
    if (rx_ticks.size() !== 4 || k0 !== 84 || rx_mids.size() !== 0) begin
      errors++;
      $display("FAIL rx_pre_realign: got n=%0d first=%0d mids=%0d expected 4 84 0",
               rx_ticks.size(), k0, rx_mids.size());
    end
    checks++;
    if ((rx_tick | rx_mid) !== 1'b0) begin
      errors++;
      $display("FAIL rx_realign_cycle: got tick=%b mid=%b expected 0/0", rx_tick, rx_mid);
    end
    rx_align = 1'b1;
    step();
    rx_align = 1'b0;
    run_rx(1100);
    m0 = (rx_mids.size() > 0) ? rx_mids[0] - a2 : -1;
    k0 = (rx_ticks.size() > 0) ? rx_ticks[0] - a2 : -1;
    checks++;
    if (rx_mids.size() !== 1 || m0 !== 672) begin
      errors++;
      $display("FAIL rx_mid_realign: got n=%0d %0d expected n=1 672", rx_mids.size(), m0);
    end
    checks++;
    if (rx_ticks.size() !== 13 || k0 !== 84) begin
      errors++;
      $display("FAIL rx_tick_realign: got n=%0d %0d expected n=13 84", rx_ticks.size(), k0);
    end
    rx_en = 1'b0;
    run_rx(300);
    checks++;
    if (rx_ticks.size() !== 0 || rx_mids.size() !== 0) begin
      errors++;
      $display("FAIL rx_en_drop: got ticks=%0d mids=%0d expected 0/0", rx_ticks.size(), rx_mids.size());
    end
    rx_en = 1'b1;
    repeat (5) step();
    baudrate_sel = 2'd3;
    step();
    checks++;
    if (rx_sel_active !== 2'd2) begin
      errors++;
      $display("FAIL rx_sel_frozen: got %0d expected 2", rx_sel_active);
    end
    rx_align = 1'b1;
    step();
    rx_align = 1'b0;
    checks++;
    if (rx_sel_active !== 2'd3) begin
      errors++;
      $display("FAIL rx_sel_align_reload: got %0d expected 3", rx_sel_active);
    end
    rx_en = 1'b0;
  endtask

  task automatic test_num_rates3();
    int e;
    int first;
    int n;
    sel3 = 2'd3;
    fifo3 = 1'b1;
    ctrl_idle_state = 1'b1;
    repeat (3) step();
    checks++;
    if (tx_sel_active3 !== 2'd0) begin
      errors++;
      $display("FAIL nr3_sel_clamp: got %0d expected 0", tx_sel_active3);
    end
    fifo3 = 1'b0;
    e = cyc;
    first = -1;
    n = 0;
    for (int i = 0; i < 5400; i++) begin
      step();
      if (tx_tick3) begin
        n++;
        if (first < 0) first = cyc - e;
      end
    end
    checks++;
    if (n !== 1 || first !== 5375) begin
      errors++;
      $display("FAIL nr3_period: got n=%0d first=%0d expected n=1 5375", n, first);
    end
    fifo3 = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time %0t expected completion before limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ctrl_gate();
    test_tx_rate();
    test_sel_freeze();
    test_rx_align();
    test_rx_realign();
    test_num_rates3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
